// File: rtl/bitblade_pkg.sv
// bitblade_pkg: function codes, FSM state encoding and default widths shared by the Bitblade accumulator.
package bitblade_pkg;
  localparam int DEF_PSUM_W = 18;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_CNT_W = 16;
  localparam logic [2:0] FN_CLEAR = 3'd0;
  localparam logic [2:0] FN_ACCUM = 3'd1;
  localparam logic [2:0] FN_READ = 3'd2;
  localparam logic [2:0] FN_READ_CLR = 3'd3;
  localparam logic [2:0] FN_COUNT = 3'd4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
endpackage

// File: rtl/bitblade_acc_add.sv
// bitblade_acc_add: acc + zero-extended psum with carry-out; clamps to all-ones on carry when
// BITBLADE_ACC_SAT_EN is defined, otherwise wraps.
module bitblade_acc_add #(
  parameter int PSUM_W = 18,
  parameter int ACC_W = 32
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PSUM_W-1:0] psum,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);
  logic [ACC_W:0] raw;
  assign raw = {1'b0, acc} + (ACC_W+1)'(psum);
  assign carry = raw[ACC_W];
`ifdef BITBLADE_ACC_SAT_EN
  assign sum = carry ? '1 : raw[ACC_W-1:0];
`else
  assign sum = raw[ACC_W-1:0];
`endif
endmodule

// File: rtl/bitblade_acc_ctrl.sv
// bitblade_acc_ctrl: cmd/rsp accumulator for Bitblade partial sums with clear/read/count commands;
// BITBLADE_ACC_SAT_EN selects clamping instead of wrapping on overflow.
module bitblade_acc_ctrl
  import bitblade_pkg::*;
#(
  parameter int PSUM_W = DEF_PSUM_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_funct,
  input  logic [PSUM_W-1:0] cmd_psum,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ACC_W-1:0]  rsp_data,
  output logic              ovf
);
  logic [1:0] state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, rsp_data_q, rsp_data_d, sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PSUM_W-1:0] psum_q, psum_d;
  logic ovf_q, ovf_d, carry;

  bitblade_acc_add #(.PSUM_W(PSUM_W), .ACC_W(ACC_W)) u_add (
    .acc(acc_q), .psum(psum_q), .sum(sum), .carry(carry)
  );

  // cmd_ready is gated by reset so nothing looks acceptable while reset is held
  assign cmd_ready = reset_n && state_q == S_IDLE;
  assign rsp_valid = state_q == S_RESP;
  assign rsp_data = rsp_data_q;
  assign ovf = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    psum_d = psum_q;
    rsp_data_d = rsp_data_q;
    if (state_q == S_IDLE && cmd_valid) begin
      state_d = (cmd_funct == FN_ACCUM) ? S_ADD : S_RESP;
      case (cmd_funct)
        FN_CLEAR: begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          rsp_data_d = '0;
        end
        FN_ACCUM: psum_d = cmd_psum;
        FN_READ: rsp_data_d = acc_q;
        FN_READ_CLR: begin
          rsp_data_d = acc_q;
          acc_d = '0;
          cnt_d = '0;
        end
        FN_COUNT: rsp_data_d = ACC_W'(cnt_q);
        default: rsp_data_d = '1;
      endcase
    end else if (state_q == S_ADD) begin
      acc_d = sum;
      rsp_data_d = sum;
      ovf_d = ovf_q | carry;
      cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
      state_d = S_RESP;
    end else if (state_q == S_RESP && rsp_ready) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      psum_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      psum_q <= psum_d;
      rsp_data_q <= rsp_data_d;
    end
  end
endmodule

// File: tb/tb_bitblade_acc_ctrl.sv
// tb_bitblade_acc_ctrl: directed and random commands checked against an arithmetic model of the accumulator.
module tb_bitblade_acc_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [2:0] cmd_funct = 3'd0;
  logic [17:0] cmd_psum = 18'd0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic ovf;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;
  logic [31:0] exp_rsp = 32'd0;
  logic exp_ovf = 1'b0;
  longint unsigned m_acc = 0;
  int m_cnt = 0;
  logic m_ovf = 1'b0;
  logic [31:0] got;

  bitblade_acc_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_funct(cmd_funct), .cmd_psum(cmd_psum), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every cycle a response is visible it must equal the model's answer, and ovf the model's flag
  always @(negedge clk) begin
    if (chk_en && reset_n && rsp_valid) begin
      tests++;
      if (rsp_data !== exp_rsp || ovf !== exp_ovf) begin
        fails++;
        $display("FAIL rsp_cycle: got data %h ovf %b expected data %h ovf %b", rsp_data, ovf, exp_rsp, exp_ovf);
      end
    end
  end

  task automatic model(input logic [2:0] f, input logic [17:0] p, output logic [31:0] r);
    longint unsigned s;
    case (f)
      3'd0: begin m_acc = 0; m_cnt = 0; m_ovf = 1'b0; r = 32'd0; end
      3'd1: begin
        s = m_acc + longint'(p);
        if (s > 64'hFFFF_FFFF) begin
          m_ovf = 1'b1;
`ifdef BITBLADE_ACC_SAT_EN
          m_acc = 64'hFFFF_FFFF;
`else
          m_acc = s - 64'h1_0000_0000;
`endif
        end else m_acc = s;
        if (m_cnt < 65535) m_cnt++;
        r = 32'(m_acc);
      end
      3'd2: r = 32'(m_acc);
      3'd3: begin r = 32'(m_acc); m_acc = 0; m_cnt = 0; end
      3'd4: r = 32'(m_cnt);
      default: r = 32'hFFFF_FFFF;
    endcase
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  // Issues one command starting at a negedge, checks latency, holds the response, returns at a negedge
  task automatic issue(input logic [2:0] f, input logic [17:0] p, input int hold, output logic [31:0] r);
    logic [31:0] e;
    int k;
    model(f, p, e);
    exp_rsp = e;
    exp_ovf = m_ovf;
    chk_en = 1'b1;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_funct = f;
    cmd_psum = p;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_psum = 18'($urandom);
    k = 1;
    while (!rsp_valid && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("latency", 32'(k), (f == 3'd1) ? 32'd2 : 32'd1);
    r = rsp_data;
    for (int i = 0; i < hold; i++) begin
      check("busy_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_done", 32'(rsp_valid), 32'd0);
  endtask

  // Back-to-back ACCUMs of one value with cmd_valid held and rsp_ready high
  task automatic preload(input int n_acc, input logic [17:0] p);
    int n = 0;
    int g = 0;
    logic [31:0] d;
    chk_en = 1'b0;
    cmd_funct = 3'd1;
    cmd_psum = p;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    while (n < n_acc && g < 4 * n_acc) begin
      if (cmd_ready) n++;
      g++;
      if (n < n_acc) @(negedge clk);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    g = 0;
    while (!cmd_ready && g < 10) begin
      @(negedge clk);
      g++;
    end
    rsp_ready = 1'b0;
    check("preload_accepts", 32'(n), 32'(n_acc));
    for (int i = 0; i < n_acc; i++) model(3'd1, p, d);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    model_reset();
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check("rst_cmd_ready_after", 32'(cmd_ready), 32'd1);
    check("rst_rsp_data", rsp_data, 32'd0);
    issue(3'd2, 18'd0, 0, got);
    check("t1_read", got, 32'd0);

    issue(3'd0, 18'd0, 0, got);
    issue(3'd1, 18'h3FFFF, 1, got);
    check("t2_acc1", got, 32'h0003_FFFF);
    issue(3'd1, 18'h00001, 0, got);
    check("t2_acc2", got, 32'h0004_0000);
    issue(3'd2, 18'd0, 2, got);
    check("t2_read", got, 32'h0004_0000);
    issue(3'd4, 18'd0, 0, got);
    check("t2_count", got, 32'd2);

    // Backpressure with a stray cmd_valid pulse that must be ignored
    model(3'd1, 18'h00100, exp_rsp);
    exp_ovf = m_ovf;
    chk_en = 1'b1;
    cmd_valid = 1'b1;
    cmd_funct = 3'd1;
    cmd_psum = 18'h00100;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_data", rsp_data, 32'h0004_0100);
      cmd_valid = (i == 2);
      cmd_funct = 3'd0;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_no_extra_rsp", 32'(rsp_valid), 32'd0);
    issue(3'd2, 18'd0, 0, got);
    check("bp_read_after", got, 32'h0004_0100);

    issue(3'd0, 18'd0, 0, got);
    preload(16384, 18'h3FFFF);
    issue(3'd1, 18'h03FF0, 0, got);
    check("ovf_preload", got, 32'hFFFF_FFF0);
    check("ovf_pre_flag", 32'(ovf), 32'd0);
    issue(3'd1, 18'h00020, 0, got);
`ifdef BITBLADE_ACC_SAT_EN
    check("ovf_acc", got, 32'hFFFF_FFFF);
    issue(3'd1, 18'h00005, 0, got);
    check("ovf_stays_clamped", got, 32'hFFFF_FFFF);
`else
    check("ovf_acc", got, 32'h0000_0010);
`endif
    check("ovf_flag", 32'(ovf), 32'd1);
    issue(3'd2, 18'd0, 0, got);
    check("ovf_sticky", 32'(ovf), 32'd1);
    issue(3'd0, 18'd0, 0, got);
    check("ovf_cleared", 32'(ovf), 32'd0);

    issue(3'd1, 18'h01234, 0, got);
    issue(3'd3, 18'd0, 0, got);
    check("rdclr_rsp", got, 32'h0000_1234);
    issue(3'd2, 18'd0, 0, got);
    check("rdclr_read", got, 32'd0);
    issue(3'd4, 18'd0, 0, got);
    check("rdclr_count", got, 32'd0);
    issue(3'd6, 18'd0, 0, got);
    check("bad_funct", got, 32'hFFFF_FFFF);

    // Reset during ADD
    issue(3'd1, 18'h00777, 0, got);
    chk_en = 1'b0;
    cmd_valid = 1'b1;
    cmd_funct = 3'd1;
    cmd_psum = 18'h00055;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    do_reset();
    issue(3'd2, 18'd0, 0, got);
    check("rst_add_read", got, 32'd0);

    // Reset during RESP
    issue(3'd1, 18'h00999, 0, got);
    chk_en = 1'b0;
    cmd_valid = 1'b1;
    cmd_funct = 3'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rst_resp_pre", 32'(rsp_valid), 32'd1);
    do_reset();
    issue(3'd2, 18'd0, 0, got);
    check("rst_resp_read", got, 32'd0);

    for (int i = 0; i < 200; i++) begin
      logic [2:0] f;
      f = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      if ($urandom_range(0, 2) != 0) f = 3'd1;
      issue(f, 18'($urandom_range(0, 18'h3FFFF)), int'($urandom_range(0, 3)), got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
